// File: rtl/wb_cmd_pkg.sv
// Shared types and widths for the Wishbone command master.
// Bus widths, FSM state encoding and the default error word.
package wb_cmd_pkg;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   localparam logic [WB_DAT_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_t;

   typedef struct packed {
      logic                we;
      logic [WB_SEL_W-1:0] sel;
      logic [WB_ADR_W-1:0] adr;
      logic [WB_DAT_W-1:0] dat;
   } wb_req_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear.
// expired flags the final permitted cycle; tied low when TIMEOUT is 0.
module wb_timeout_ctr #(
   parameter int TIMEOUT   = 255,
   parameter int TIMEOUT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_in;
         assign unused_in = ^{clk, rst, clear, enable};
         assign expired   = 1'b0;
      end else begin : g_on
         localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

         logic [TIMEOUT_W-1:0] cnt;

         always_ff @(posedge clk) begin
            if (rst || clear) begin
               cnt <= '0;
            end else if (enable) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign expired = enable && (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in, one single read/write
// cycle out, one response back, with a timeout on a silent responder.
module wb_cmd_master
   import wb_cmd_pkg::*;
#(
   parameter int                   TIMEOUT   = 255,
   parameter int                   TIMEOUT_W = 8,
   parameter logic [WB_DAT_W-1:0]  ERR_DATA  = ERR_DATA_DEF
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,

   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [WB_ADR_W-1:0] cmd_adr_i,
   input  logic [WB_DAT_W-1:0] cmd_dat_i,
   input  logic [WB_SEL_W-1:0] cmd_sel_i,

   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [WB_DAT_W-1:0] rsp_dat_o,
   output logic                rsp_err_o,

   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [WB_SEL_W-1:0] wbm_sel_o,
   output logic [WB_ADR_W-1:0] wbm_adr_o,
   output logic [WB_DAT_W-1:0] wbm_dat_o,
   input  logic                wbm_ack_i,
   input  logic [WB_DAT_W-1:0] wbm_dat_i,

   output logic                busy_o,
   output logic [15:0]         txn_cnt_o,
   output logic [15:0]         err_cnt_o
);

   state_t  state;
   wb_req_t req;
   logic    accept;
   logic    in_bus;
   logic    expired;

   assign accept = (state == IDLE) && cmd_valid_i;
   assign in_bus = (state == BUS);

   wb_timeout_ctr #(
      .TIMEOUT   (TIMEOUT),
      .TIMEOUT_W (TIMEOUT_W)
   ) u_tmo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clear   (accept),
      .enable  (in_bus),
      .expired (expired)
   );

   // Request fields stay registered after the cycle ends so the bus
   // does not toggle needlessly between transactions.
   assign wbm_we_o  = req.we;
   assign wbm_sel_o = req.sel;
   assign wbm_adr_o = req.adr;
   assign wbm_dat_o = req.dat;
   assign busy_o    = (state != IDLE);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         req         <= '0;
         cmd_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         txn_cnt_o   <= '0;
         err_cnt_o   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  req.we      <= cmd_we_i;
                  req.sel     <= cmd_sel_i;
                  req.adr     <= cmd_adr_i;
                  req.dat     <= cmd_dat_i;
                  wbm_cyc_o   <= 1'b1;
                  wbm_stb_o   <= 1'b1;
                  cmd_ready_o <= 1'b0;
                  state       <= BUS;
               end
            end
            BUS: begin
               // An ack coincident with expiry still completes normally.
               if (wbm_ack_i) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_dat_o   <= req.we ? '0 : wbm_dat_i;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  txn_cnt_o   <= txn_cnt_o + 16'd1;
                  state       <= RESP;
               end else if (expired) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_dat_o   <= ERR_DATA;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  if (err_cnt_o != 16'hFFFF) begin
                     err_cnt_o <= err_cnt_o + 16'd1;
                  end
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: two instances (TIMEOUT 8 and 4)
// share one stimulus stream; each test checks the instance it targets.
module tb_wb_cmd_master;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_ready;
   logic        ack;
   logic [31:0] rdat;

   logic        a_cmd_ready, b_cmd_ready;
   logic        a_rsp_valid, b_rsp_valid;
   logic [31:0] a_rsp_dat,   b_rsp_dat;
   logic        a_rsp_err,   b_rsp_err;
   logic        a_cyc,       b_cyc;
   logic        a_stb,       b_stb;
   logic        a_we,        b_we;
   logic [3:0]  a_sel,       b_sel;
   logic [31:0] a_adr,       b_adr;
   logic [31:0] a_wdat,      b_wdat;
   logic        a_busy,      b_busy;
   logic [15:0] a_txn,       b_txn;
   logic [15:0] a_err,       b_err;

   int n_tests = 0;
   int n_fail  = 0;

   wb_cmd_master #(.TIMEOUT(8), .TIMEOUT_W(8)) u_a (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(a_cmd_ready),
      .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
      .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_dat_o(a_rsp_dat), .rsp_err_o(a_rsp_err),
      .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we),
      .wbm_sel_o(a_sel), .wbm_adr_o(a_adr), .wbm_dat_o(a_wdat),
      .wbm_ack_i(ack), .wbm_dat_i(rdat),
      .busy_o(a_busy), .txn_cnt_o(a_txn), .err_cnt_o(a_err)
   );

   wb_cmd_master #(.TIMEOUT(4), .TIMEOUT_W(3)) u_b (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(b_cmd_ready),
      .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
      .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_dat_o(b_rsp_dat), .rsp_err_o(b_rsp_err),
      .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we),
      .wbm_sel_o(b_sel), .wbm_adr_o(b_adr), .wbm_dat_o(b_wdat),
      .wbm_ack_i(ack), .wbm_dat_i(rdat),
      .busy_o(b_busy), .txn_cnt_o(b_txn), .err_cnt_o(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Present one command for exactly the accepting edge.
   task automatic send(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Responder: ack on BUS cycle ack_at (1-based, 0 = never) and count
   // how many cycles each instance holds cyc high.
   task automatic run_bus(input int ack_at, input logic [31:0] data,
                          output int ca, output int cb);
      ca = 0;
      cb = 0;
      for (int n = 1; n <= 40 && (a_cyc || b_cyc); n++) begin
         if (a_cyc) ca++;
         if (b_cyc) cb++;
         ack  = (n == ack_at);
         rdat = data;
         tick();
         ack  = 1'b0;
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int ca, cb, acc, rises, last_acc, t;
      logic prev_cyc, will_acc;

      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
      cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      rsp_ready = 1'b0; ack = 1'b0; rdat = '0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_cmd_ready", a_cmd_ready, 1);
      check("rst_cyc",       a_cyc, 0);
      check("rst_rsp_valid", a_rsp_valid, 0);
      check("rst_busy",      a_busy, 0);
      check("rst_adr",       a_adr, 0);
      check("rst_txn",       a_txn, 0);

      // 1: write, ack on the 2nd BUS cycle
      send(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
      check("t1_cyc",  a_cyc, 1);
      check("t1_stb",  a_stb, 1);
      check("t1_we",   a_we, 1);
      check("t1_adr",  a_adr, 32'h3000_0004);
      check("t1_dat",  a_wdat, 32'hA5A5_1234);
      check("t1_sel",  a_sel, 4'hF);
      check("t1_busy", a_busy, 1);
      run_bus(2, 32'h1111_1111, ca, cb);
      check("t1_cyc_len", ca, 2);
      check("t1_valid",   a_rsp_valid, 1);
      check("t1_rdat",    a_rsp_dat, 0);
      check("t1_err",     a_rsp_err, 0);
      check("t1_txn",     a_txn, 1);
      finish_rsp();
      check("t1_ready_back", a_cmd_ready, 1);

      // 2: read, immediate ack, response back-pressured 5 cycles
      send(1'b0, 32'h300F_FFF8, 32'h0, 4'hF);
      check("t2_adr", a_adr, 32'h300F_FFF8);
      check("t2_we",  a_we, 0);
      run_bus(1, 32'hCAFE_0001, ca, cb);
      check("t2_cyc_len", ca, 1);
      check("t2_valid",   a_rsp_valid, 1);
      check("t2_rdat",    a_rsp_dat, 32'hCAFE_0001);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_hold_valid", a_rsp_valid, 1);
         check("t2_hold_dat",   a_rsp_dat, 32'hCAFE_0001);
         check("t2_hold_ready", a_cmd_ready, 0);
      end
      finish_rsp();
      check("t2_txn", a_txn, 2);

      // 3: read with no ack; A times out after 8, B after 4
      send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      run_bus(0, 32'h0, ca, cb);
      check("t3_cyc_len_a", ca, 8);
      check("t3_cyc_len_b", cb, 4);
      check("t3_err",       a_rsp_err, 1);
      check("t3_rdat",      a_rsp_dat, 32'hDEAD_BEEF);
      check("t3_err_cnt",   a_err, 1);
      check("t3_txn",       a_txn, 2);
      check("t3_err_cnt_b", b_err, 1);
      finish_rsp();

      // 4: on B, ack lands on BUS cycle 4, the expiry cycle
      send(1'b0, 32'h3000_0020, 32'h0, 4'hF);
      run_bus(4, 32'h1234_5678, ca, cb);
      check("t4_cyc_len_b", cb, 4);
      check("t4_err_b",     b_rsp_err, 0);
      check("t4_rdat_b",    b_rsp_dat, 32'h1234_5678);
      check("t4_err_cnt_b", b_err, 1);
      check("t4_txn_b",     b_txn, 3);
      finish_rsp();

      // 5: reset in the 3rd BUS cycle of a read
      send(1'b0, 32'h3000_0030, 32'h0, 4'hF);
      tick();
      tick();
      check("t5_pre_cyc", a_cyc, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_cyc",   a_cyc, 0);
      check("t5_stb",   a_stb, 0);
      check("t5_valid", a_rsp_valid, 0);
      check("t5_ready", a_cmd_ready, 1);
      tick();
      tick();
      check("t5_no_rsp", a_rsp_valid, 0);
      send(1'b1, 32'h3000_0040, 32'h0000_00FF, 4'h1);
      check("t5_sel", a_sel, 4'h1);
      run_bus(1, 32'h0, ca, cb);
      check("t5_valid2", a_rsp_valid, 1);
      check("t5_err2",   a_rsp_err, 0);
      check("t5_txn",    a_txn, 1);
      finish_rsp();

      // 6: 10 back-to-back writes, fresh counters
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      cmd_we    = 1'b1;
      cmd_adr   = 32'h3000_0100;
      cmd_dat   = 32'h0;
      cmd_sel   = 4'hF;
      cmd_valid = 1'b1;
      acc = 0; rises = 0; last_acc = -1; prev_cyc = 1'b0;
      for (t = 0; t < 200 && !(acc == 10 && !a_cyc && !a_rsp_valid);
           t++) begin
         if (a_cyc && !prev_cyc) rises++;
         prev_cyc = a_cyc;
         will_acc = cmd_valid && a_cmd_ready;
         ack  = a_cyc || (a_cmd_ready && acc == 4);
         tick();
         ack  = 1'b0;
         if (will_acc) begin
            acc++;
            cmd_dat = cmd_dat + 32'd1;
            if (last_acc >= 0) check("t6_gap", t - last_acc, 3);
            last_acc = t;
            if (acc == 10) cmd_valid = 1'b0;
         end
      end
      check("t6_accepts", acc, 10);
      ack = 1'b1;
      tick();
      tick();
      ack = 1'b0;
      check("t6_rises", rises, 10);
      check("t6_txn",   a_txn, 10);
      check("t6_err",   a_err, 0);
      check("t6_idle",  a_busy, 0);
      check("t6_cyc",   a_cyc, 0);
      check("t6_valid", a_rsp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
